// File: rtl/link_ddr_downstream_multi.sv
// N-channel DDR-style downstream receiver: pairs of io beats become double-width
// words in per-channel FIFOs, dequeued together under valid/yumi with credit tokens.
module link_ddr_downstream_multi #(
  parameter int channel_width        = 8,
  parameter int num_channels         = 2,
  parameter int fifo_els             = 4,
  parameter int lg_credit_decimation = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [num_channels-1:0]                 io_valid_i,
  input  logic [num_channels*channel_width-1:0]   io_data_i,
  output logic [2*channel_width*num_channels-1:0] core_data_o,
  output logic                                    core_valid_o,
  input  logic                                    core_yumi_i,
  output logic [num_channels-1:0]                 token_o,
  output logic [num_channels-1:0]                 overflow_o
);

  localparam int IDX_W  = $clog2(fifo_els);
  localparam int PTR_W  = IDX_W + 1;
  localparam int WORD_W = 2 * channel_width;

  logic [num_channels-1:0] empty;
  logic [num_channels-1:0] full;
  logic                    deq;
  logic                    cnt_wrap;

  assign core_valid_o = &(~empty);
  assign deq          = core_yumi_i & core_valid_o;

  // Dequeue is common to every channel, so one decimation counter serves all tokens.
  if (lg_credit_decimation == 0) begin : g_nocnt
    assign cnt_wrap = 1'b1;
  end else begin : g_cnt
    logic [lg_credit_decimation-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (deq) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_wrap = &cnt_q;
  end

  for (genvar c = 0; c < num_channels; c++) begin : g_ch
    logic                     phase_q, phase_d;
    logic [channel_width-1:0] half_q, half_d;
    logic [channel_width-1:0] beat;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [PTR_W-1:0]         rptr_q, rptr_d;
    logic                     ovf_q, ovf_d;
    logic                     tok_q, tok_d;
    logic                     complete;
    logic                     enq;
    logic [WORD_W-1:0]        mem_q [fifo_els];

    assign beat     = io_data_i[c*channel_width +: channel_width];
    assign empty[c] = (wptr_q == rptr_q);
    assign full[c]  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                      (wptr_q[IDX_W] != rptr_q[IDX_W]);

    assign core_data_o[c*WORD_W +: WORD_W] = mem_q[rptr_q[IDX_W-1:0]];
    assign token_o[c]    = tok_q;
    assign overflow_o[c] = ovf_q;

    always_comb begin
      phase_d  = phase_q;
      half_d   = half_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      ovf_d    = ovf_q;
      tok_d    = tok_q;
      complete = io_valid_i[c] & phase_q;
      // A full FIFO can still take the word when the same-cycle dequeue frees a slot.
      enq      = complete & (~full[c] | deq);
      if (io_valid_i[c]) begin
        phase_d = ~phase_q;
        if (!phase_q) half_d = beat;
      end
      if (enq)              wptr_d = wptr_q + 1'b1;
      if (complete && !enq) ovf_d  = 1'b1;
      if (deq)              rptr_d = rptr_q + 1'b1;
      if (deq && cnt_wrap)  tok_d  = ~tok_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_q <= 1'b0;
        half_q  <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
        ovf_q   <= 1'b0;
        tok_q   <= 1'b0;
      end else begin
        phase_q <= phase_d;
        half_q  <= half_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        ovf_q   <= ovf_d;
        tok_q   <= tok_d;
      end
    end

    // Second beat lands in the upper half of the stored word.
    always_ff @(posedge clk) begin
      if (enq) mem_q[wptr_q[IDX_W-1:0]] <= {beat, half_q};
    end
  end

endmodule

// File: tb/tb_link_ddr_downstream_multi.sv
// Directed bench for link_ddr_downstream_multi at default parameters (8-bit beats, 2 channels, depth 4).
module tb_link_ddr_downstream_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  io_valid_i = '0;
  logic [15:0] io_data_i = '0;
  logic [31:0] core_data_o;
  logic        core_valid_o;
  logic        core_yumi_i = 1'b0;
  logic [1:0]  token_o;
  logic [1:0]  overflow_o;

  int checks = 0;
  int errors = 0;

  link_ddr_downstream_multi dut (
    .clk         (clk),
    .rst         (rst),
    .io_valid_i  (io_valid_i),
    .io_data_i   (io_data_i),
    .core_data_o (core_data_o),
    .core_valid_o(core_valid_o),
    .core_yumi_i (core_yumi_i),
    .token_o     (token_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  // Word k on channel ch: low beat 4k+2ch, high beat 4k+2ch+1.
  function automatic logic [15:0] wd(input int ch, input int k);
    logic [7:0] lo;
    lo = 8'(k*4 + ch*2);
    return {lo + 8'd1, lo};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic y);
    io_valid_i  = v;
    io_data_i   = {d1, d0};
    core_yumi_i = y;
    @(posedge clk); #1;
    io_valid_i  = '0;
    core_yumi_i = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] v, input int k);
    logic [15:0] w0, w1;
    w0 = wd(0, k);
    w1 = wd(1, k);
    drive(v, w0[7:0], w1[7:0], 1'b0);
    drive(v, w0[15:8], w1[15:8], 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", core_valid_o); end
    checks++; if (token_o !== 2'b00) begin errors++; $display("FAIL reset_token got %b want 00", token_o); end
    checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL reset_ovf got %b want 00", overflow_o); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(2'b11, 8'h11, 8'h33, 1'b0);
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL basic_half_valid got %b want 0", core_valid_o); end
    drive(2'b11, 8'h22, 8'h44, 1'b0);
    checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", core_valid_o); end
    checks++; if (core_data_o !== 32'h4433_2211) begin errors++; $display("FAIL basic_data got %h want 44332211", core_data_o); end
  endtask

  task automatic test_gap();
    do_reset();
    drive(2'b01, 8'h01, 8'h00, 1'b0);
    drive(2'b01, 8'h02, 8'h00, 1'b0);
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL gap_one_chan_valid got %b want 0", core_valid_o); end
    drive(2'b10, 8'h00, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'b00, 8'h00, 8'h00, 1'b0);
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL gap_mid_valid got %b want 0", core_valid_o); end
    drive(2'b10, 8'h00, 8'hBB, 1'b0);
    checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", core_valid_o); end
    checks++; if (core_data_o !== 32'hBBAA_0201) begin errors++; $display("FAIL gap_data got %h want bbaa0201", core_data_o); end
  endtask

  task automatic test_tokens();
    logic [1:0] exp_tok;
    do_reset();
    for (int k = 0; k < 4; k++) send_word(2'b11, k);
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_data_o !== {wd(1, i), wd(0, i)}) begin errors++; $display("FAIL tok_data[%0d] got %h want %h", i, core_data_o, {wd(1, i), wd(0, i)}); end
      drive(2'b00, 8'h00, 8'h00, 1'b1);
      exp_tok = (i == 1 || i == 2) ? 2'b11 : 2'b00;
      checks++; if (token_o !== exp_tok) begin errors++; $display("FAIL tok_after_deq[%0d] got %b want %b", i + 1, token_o, exp_tok); end
    end
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL tok_drained_valid got %b want 0", core_valid_o); end
    drive(2'b00, 8'h00, 8'h00, 1'b1);
    drive(2'b00, 8'h00, 8'h00, 1'b1);
    checks++; if (token_o !== 2'b00) begin errors++; $display("FAIL tok_idle_yumi got %b want 00", token_o); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp0 [4];
    do_reset();
    for (int k = 0; k < 4; k++) send_word(2'b01, k);
    checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL ovf_full_no_ovf got %b want 00", overflow_o); end
    drive(2'b01, 8'hEE, 8'h00, 1'b0);
    drive(2'b01, 8'hFF, 8'h00, 1'b0);
    checks++; if (overflow_o !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b want 01", overflow_o); end
    send_word(2'b10, 0);
    checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", core_valid_o); end
    checks++; if (core_data_o[15:0] !== wd(0, 0)) begin errors++; $display("FAIL ovf_head got %h want %h", core_data_o[15:0], wd(0, 0)); end
    drive(2'b01, 8'hEE, 8'h00, 1'b0);
    drive(2'b01, 8'hFF, 8'h00, 1'b1);
    checks++; if (overflow_o !== 2'b01) begin errors++; $display("FAIL ovf_deq_accept got %b want 01", overflow_o); end
    for (int k = 1; k < 5; k++) send_word(2'b10, k);
    checks++; if (overflow_o !== 2'b01) begin errors++; $display("FAIL ovf_ch1_fill got %b want 01", overflow_o); end
    exp0[0] = wd(0, 1); exp0[1] = wd(0, 2); exp0[2] = wd(0, 3); exp0[3] = 16'hFFEE;
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_data_o !== {wd(1, i + 1), exp0[i]}) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", i, core_data_o, {wd(1, i + 1), exp0[i]}); end
      drive(2'b00, 8'h00, 8'h00, 1'b1);
    end
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got %b want 0", core_valid_o); end
  endtask

  task automatic test_back_to_back();
    int rd;
    logic [15:0] w0, w1;
    do_reset();
    rd = 0;
    for (int cyc = 0; cyc < 60 && rd < 20; cyc++) begin
      core_yumi_i = core_valid_o;
      if (core_valid_o) begin
        checks++; if (core_data_o !== {wd(1, rd), wd(0, rd)}) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", rd, core_data_o, {wd(1, rd), wd(0, rd)}); end
        rd++;
      end
      if (cyc < 40) begin
        w0 = wd(0, cyc / 2);
        w1 = wd(1, cyc / 2);
        io_valid_i = 2'b11;
        io_data_i  = (cyc % 2 == 0) ? {w1[7:0], w0[7:0]} : {w1[15:8], w0[15:8]};
      end else begin
        io_valid_i = 2'b00;
      end
      @(posedge clk); #1;
      io_valid_i  = '0;
      core_yumi_i = 1'b0;
    end
    checks++; if (rd !== 20) begin errors++; $display("FAIL stream_count got %0d want 20", rd); end
    checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL stream_ovf got %b want 00", overflow_o); end
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL stream_empty got %b want 0", core_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(2'b11, 0);
    send_word(2'b11, 1);
    drive(2'b00, 8'h00, 8'h00, 1'b1);
    drive(2'b00, 8'h00, 8'h00, 1'b1);
    checks++; if (token_o !== 2'b11) begin errors++; $display("FAIL mid_pre_token got %b want 11", token_o); end
    send_word(2'b11, 2);
    drive(2'b01, 8'h99, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", core_valid_o); end
    checks++; if (token_o !== 2'b00) begin errors++; $display("FAIL mid_token got %b want 00", token_o); end
    checks++; if (overflow_o !== 2'b00) begin errors++; $display("FAIL mid_ovf got %b want 00", overflow_o); end
    drive(2'b11, 8'h55, 8'h01, 1'b0);
    drive(2'b11, 8'h66, 8'h02, 1'b0);
    checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL mid_after_valid got %b want 1", core_valid_o); end
    checks++; if (core_data_o !== 32'h0201_6655) begin errors++; $display("FAIL mid_after_data got %h want 02016655", core_data_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_tokens();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
